if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the fetch PC and issues one word-aligned request at a time to instruction memory over a grant/valid handshake. It holds the IF/ID pipeline register that drives the decode stage's `instr` and `pc_plus4` inputs, with a one-entry skid buffer for decode stalls. It accepts jump/branch redirects, for example the decode stage's `jump_target`, and squashes wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `stall`  in  1  decode cannot accept; hold the IF/ID register
- `redirect_valid`  in  1  one-cycle pulse; fetch restarts at `redirect_pc`
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and forced to 0
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  request address (fetch PC)
- `imem_gnt`  in  1  request accepted this cycle (`imem_req && imem_gnt`)
- `imem_rvalid`  in  1  response valid; at least 1 cycle after grant
- `imem_rdata`  in  32  instruction word, qualified by `imem_rvalid`
- `id_valid`  out  1  IF/ID register holds a real instruction
- `instr`  out  32  IF/ID instruction; 32'h0 (nop) whenever `id_valid`=0
- `pc_plus4`  out  32  address of `instr` + 4, modulo 2^32

## Operation
- Registered state:
  - `fetch_pc`
  - FSM {REQ, WAIT}
  - `req_pc`: address of the outstanding request
  - `kill`: discard the next response
  - skid buffer: `skid_valid`, `skid_instr`, `skid_pc4`
  - IF/ID register: `id_valid`, `instr`, `pc_plus4`
- Reset (`rst_n`=0 at a clock edge):
  - `fetch_pc`=RESET_PC, FSM=REQ.
  - `kill`, `skid_valid`, `id_valid` all 0; `instr`=0; `pc_plus4`=0.
  - `imem_req`=0 while `rst_n`=0.
- REQ:
  - `imem_req`=!`skid_valid`; `imem_addr`=`fetch_pc`.
  - On grant: `req_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4 (wraps at 2^32), go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`, go to REQ. If `kill`=1, drop the response and clear `kill`. Otherwise deliver {`imem_rdata`, `req_pc`+4}.
- IF/ID advance (no redirect):
  - `stall`=1: IF/ID holds. A delivered word goes into the skid buffer. Skid is never full on delivery, because no request is issued while `skid_valid`=1.
  - `stall`=0: IF/ID loads from skid if `skid_valid`, else from the delivered word. If neither is present, `id_valid`<=0 (bubble, `instr`=0).
  - A word delivered while skid is valid and `stall`=0 is impossible (no request issued while `skid_valid`=1).
- Redirect (`redirect_valid`=1) has priority over everything except reset:
  - `fetch_pc`<=`redirect_pc` & ~3. `id_valid`<=0 and `instr`<=0 regardless of `stall`. `skid_valid`<=0.
  - In WAIT without `imem_rvalid`: `kill`<=1, stay in WAIT.
  - In WAIT with `imem_rvalid`: drop the response, `kill`<=0, go to REQ.
  - In REQ with grant the same cycle: that request is wrong-path. `kill`<=1, go to WAIT; `fetch_pc` still takes `redirect_pc`.
  - In REQ without grant: stay in REQ. The next request uses the new PC.
- `pc_plus4` arithmetic is 32-bit unsigned, wrapping; `req_pc`=32'hFFFF_FFFC yields `pc_plus4`=0.

## Timing
- Single outstanding request. Peak throughput is 1 instruction per 2 cycles (REQ grant cycle, then WAIT response cycle).
- Grant in cycle t, `imem_rvalid` in t+1: the instruction is visible on `instr`/`id_valid` in cycle t+2.
- `imem_req`/`imem_addr` depend combinationally only on FSM, `skid_valid` and `fetch_pc`, never on `imem_gnt`.
- IF/ID outputs are registered; no combinational path from `imem_rdata` to `instr`.
- `redirect_valid` in cycle t: `id_valid`=0 in t+1. The first request at `redirect_pc` is issued in t+1 if the FSM is in REQ, otherwise after the killed response returns.
- Reset asserted mid-WAIT:
  - The outstanding response arriving after reset is ignored. While `rst_n`=0 the stage is held. The first post-reset cycle is REQ.
  - Memory must not return a response for a pre-reset request after reset deasserts.

## Test plan
- Reset with RESET_PC=32'h0000_0040: `id_valid`=0, `instr`=0, `imem_req`=0 during reset. First post-reset cycle: `imem_req`=1, `imem_addr`=32'h40.
- Zero-wait memory (gnt=1, rvalid one cycle later), words at 0x40/0x44/0x48: `id_valid` pulses every other cycle with `pc_plus4`=0x44, 0x48, 0x4C; `instr` matches the memory words.
- `stall`=1 held 4 cycles while a response arrives:
  - IF/ID unchanged; skid captures the word; `imem_req`=0 while skid is full.
  - On `stall`=0: IF/ID loads the skid word, then fetching resumes at the next PC.
- `redirect_valid` to 32'h0000_0103 while in WAIT, rvalid two cycles later:
  - `id_valid`=0 next cycle; the late word is discarded.
  - Next request has `imem_addr`=32'h100; delivered `pc_plus4`=32'h104.
- `redirect_valid` coincident with a grant, and separately coincident with `imem_rvalid`: the wrong-path word never appears with `id_valid`=1; the next `imem_addr` equals the redirect target.
- `fetch_pc`=32'hFFFF_FFFC: delivered `pc_plus4`=0; next `imem_addr`=0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with single-outstanding imem handshake and IF/ID skid buffer
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);
    typedef enum logic {REQ, WAIT} state_t;
    state_t state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n, req_pc, skid_instr, skid_pc4;
    logic kill, kill_n, skid_valid, granted, resp, deliver;

    assign imem_req  = rst_n && state == REQ && !skid_valid;
    assign imem_addr = fetch_pc;
    assign granted   = imem_req && imem_gnt;
    assign resp      = state == WAIT && imem_rvalid;
    assign deliver   = resp && !kill && !redirect_valid;

    // next state: a redirect marks any request still in flight (or granted now) for discard
    always_comb begin
        state_n    = granted ? WAIT : resp ? REQ : state;
        kill_n     = redirect_valid ? (granted || (state == WAIT && !imem_rvalid)) : resp ? 1'b0 : kill;
        fetch_pc_n = redirect_valid ? (redirect_pc & ~32'd3) : granted ? fetch_pc + 32'd4 : fetch_pc;
    end

    // FSM, kill flag and fetch PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= REQ;
            kill     <= 1'b0;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            kill     <= kill_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    // remember the address of the outstanding request to form pc_plus4 on delivery
    always_ff @(posedge clk) begin
        if (granted) req_pc <= fetch_pc;
    end

    // IF/ID register with one-entry skid; no request issues while skid is full, so it never overflows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            id_valid   <= 1'b0;
            instr      <= 32'h0;
            pc_plus4   <= 32'h0;
        end else if (redirect_valid) begin
            skid_valid <= 1'b0;
            id_valid   <= 1'b0;
            instr      <= 32'h0;
        end else if (stall) begin
            if (deliver) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc4   <= req_pc + 32'd4;
            end
        end else begin
            skid_valid <= 1'b0;
            id_valid   <= skid_valid || deliver;
            instr      <= skid_valid ? skid_instr : deliver ? imem_rdata : 32'h0;
            pc_plus4   <= skid_valid ? skid_pc4 : deliver ? req_pc + 32'd4 : pc_plus4;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage against a behavioural instruction memory
module tb_if_stage;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, instr, pc_plus4;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        gnt_en = 1'b0, gap_chk = 1'b0;
    logic [31:0] block_addr = 32'hFFFF_FFFF;
    int          lat = 1;
    int          n_chk = 0, n_fail = 0, cyc = 0, last_cyc = -1;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;
    logic        m_pending = 1'b0;
    logic [31:0] m_addr = 32'h0;
    int          m_cnt = 0;

    if_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .instr(instr), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] p4);
        sb.push_back({mem_word(a), p4});
    endtask

    task automatic wait_sb(input int n, input string tag);
        for (int b = 0; b < 60 && sb.size() != n; b++) @(negedge clk);
        check(tag, sb.size(), n);
    endtask

    // memory: grants when enabled and address not blocked, answers lat cycles after grant
    initial forever begin
        @(posedge clk);
        #3;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        if (!rst_n) begin
            m_pending = 1'b0;
            imem_gnt  = 1'b0;
        end else begin
            if (m_pending && m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_addr);
                m_pending   = 1'b0;
            end else if (m_pending) m_cnt--;
            imem_gnt = gnt_en && imem_addr != block_addr;
            if (imem_req && imem_gnt) begin
                m_pending = 1'b1;
                m_addr    = imem_addr;
                m_cnt     = lat - 1;
            end
        end
    end

    // monitor: each newly loaded IF/ID word is popped and compared; bubbles must carry a nop
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (id_valid === 1'b1 && !stall) begin
            if (sb.size() != 0) mon_exp = sb.pop_front();
            else mon_exp = '1;
            check("instr_pc4", {instr, pc_plus4}, mon_exp);
            if (gap_chk && last_cyc >= 0) check("issue_gap", cyc - last_cyc, 2);
            last_cyc = cyc;
        end else if (id_valid !== 1'b1) check("bubble", {id_valid, instr}, 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_req", imem_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_instr", instr, 0);
        rst_n = 1'b1;
        #1;
        check("first_req", {imem_req, imem_addr}, {1'b1, 32'h40});
        gnt_en = 1'b1; block_addr = 32'h4C; gap_chk = 1'b1;
        push(32'h40, 32'h44); push(32'h44, 32'h48); push(32'h48, 32'h4C);
        wait_sb(0, "drain_seq"); tick(2);
        gap_chk = 1'b0;
        check("seq_next", {imem_req, imem_addr}, {1'b1, 32'h4C});
        push(32'h4C, 32'h50); push(32'h50, 32'h54); block_addr = 32'h54;
        wait_sb(1, "pre_stall");
        stall = 1'b1;
        tick(4);
        check("stall_req", imem_req, 0);
        check("stall_valid", id_valid, 1);
        check("stall_hold", {instr, pc_plus4}, {mem_word(32'h4C), 32'h50});
        stall = 1'b0;
        wait_sb(0, "drain_stall"); tick(2);
        check("resume_addr", {imem_req, imem_addr}, {1'b1, 32'h54});
        lat = 3; block_addr = 32'h58;
        tick(2);
        check("wait_req", imem_req, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h103; lat = 1; block_addr = 32'h104;
        push(32'h100, 32'h104);
        tick();
        redirect_valid = 1'b0;
        check("redir_wait_bubble", id_valid, 0);
        wait_sb(0, "drain_redir_wait"); tick(2);
        check("redir_wait_next", {imem_req, imem_addr}, {1'b1, 32'h104});
        block_addr = 32'h204;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        push(32'h200, 32'h204);
        tick();
        redirect_valid = 1'b0;
        check("redir_gnt_bubble", id_valid, 0);
        wait_sb(0, "drain_redir_gnt"); tick(2);
        check("redir_gnt_next", {imem_req, imem_addr}, {1'b1, 32'h204});
        block_addr = 32'h304;
        tick(2);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        push(32'h300, 32'h304);
        tick();
        redirect_valid = 1'b0;
        check("redir_rv_addr", {imem_req, imem_addr}, {1'b1, 32'h300});
        check("redir_rv_bubble", id_valid, 0);
        wait_sb(0, "drain_redir_rv"); tick(2);
        gnt_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
        gnt_en = 1'b1; block_addr = 32'h4;
        push(32'hFFFF_FFFC, 32'h0); push(32'h0, 32'h4);
        wait_sb(0, "drain_wrap"); tick(2);
        check("wrap_next", {imem_req, imem_addr}, {1'b1, 32'h4});
        check("sb_final", sb.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
